// File: rtl/m68k_mem_bridge.sv
// m68k_mem_bridge: bridges the asynchronous 68000 bus onto the on-chip word
// memory's strobe/ack interface. CPU strobes are double-flop synchronised.
// Accesses that decode to the MEM_BASE window become one memory transaction.
// DTACK is returned once the memory acks.
// Optional bus-error timeout: define BUS_TIMEOUT_EN.
module m68k_mem_bridge #(
  parameter logic [5:0] MEM_BASE = 6'h00
`ifdef BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [23:1] cpu_addr_i,
  input  logic        cpu_as_n_i,
  input  logic        cpu_uds_n_i,
  input  logic        cpu_lds_n_i,
  input  logic        cpu_rw_i,
  input  logic [15:0] cpu_data_out_i,
  output logic [15:0] cpu_data_in_o,
  output logic        cpu_dtack_n_o,
  output logic        cpu_berr_n_o,
  output logic [17:0] mem_addr_o,
  output logic [15:0] mem_data_write_o,
  input  logic [15:0] mem_data_read_i,
  output logic        mem_uds_o,
  output logic        mem_lds_o,
  output logic        mem_rw_o,
  input  logic        mem_ack_i,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DTACK    = 3'd3,
    ST_BERR     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        as_m_q, as_s_q, uds_m_q, uds_s_q, lds_m_q, lds_s_q;
  logic [17:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_write_q, mem_data_write_d;
  logic [15:0] cpu_data_in_q, cpu_data_in_d;
  logic        mem_uds_q, mem_uds_d, mem_lds_q, mem_lds_d, mem_rw_q, mem_rw_d;
  logic        cpu_dtack_n_q, cpu_dtack_n_d, cpu_berr_n_q, cpu_berr_n_d;
  // One cycle of forced idle after strobes drop, so a new access cannot
  // re-raise them until they have been low for at least two cycles.
  logic        recover_q, recover_d;
  logic        sel, timeout;
  logic [15:0] rd_lanes;

  // Two-flop synchronisers for the asynchronous strobes, preset inactive.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      as_m_q  <= 1'b1; as_s_q  <= 1'b1;
      uds_m_q <= 1'b1; uds_s_q <= 1'b1;
      lds_m_q <= 1'b1; lds_s_q <= 1'b1;
    end else begin
      as_m_q  <= cpu_as_n_i;  as_s_q  <= as_m_q;
      uds_m_q <= cpu_uds_n_i; uds_s_q <= uds_m_q;
      lds_m_q <= cpu_lds_n_i; lds_s_q <= lds_m_q;
    end
  end

  assign sel = !as_s_q && (!uds_s_q || !lds_s_q) &&
               (cpu_addr_i[23:18] == MEM_BASE) && !recover_q;

  // Lanes without a strobe return zero to the CPU.
  assign rd_lanes = {mem_uds_q ? mem_data_read_i[15:8] : 8'h00,
                     mem_lds_q ? mem_data_read_i[7:0]  : 8'h00};

`ifdef BUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Cycle counter: cleared while idle with AS released, runs while AS is
  // held without DTACK (unselected address or a memory that never acks).
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && as_s_q) cnt_d = 16'd0;
    else if (!as_s_q && cpu_dtack_n_q && state_q != ST_BERR) cnt_d = cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= 16'd0;
    else         cnt_q <= cnt_d;
  end

  assign timeout = (state_q != ST_BERR) && !as_s_q && cpu_dtack_n_q &&
                   (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= ST_IDLE;
      mem_addr_q       <= 18'd0;
      mem_data_write_q <= 16'd0;
      cpu_data_in_q    <= 16'd0;
      mem_uds_q        <= 1'b0;
      mem_lds_q        <= 1'b0;
      mem_rw_q         <= 1'b1;
      cpu_dtack_n_q    <= 1'b1;
      cpu_berr_n_q     <= 1'b1;
      recover_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      mem_addr_q       <= mem_addr_d;
      mem_data_write_q <= mem_data_write_d;
      cpu_data_in_q    <= cpu_data_in_d;
      mem_uds_q        <= mem_uds_d;
      mem_lds_q        <= mem_lds_d;
      mem_rw_q         <= mem_rw_d;
      cpu_dtack_n_q    <= cpu_dtack_n_d;
      cpu_berr_n_q     <= cpu_berr_n_d;
      recover_q        <= recover_d;
    end
  end

  // Next-state logic; an aborted access (AS released) still waits for the ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (timeout) state_d = ST_BERR;
                   else if (sel) state_d = ST_REQ;
      ST_REQ:      state_d = timeout ? ST_BERR : ST_WAIT_ACK;
      ST_WAIT_ACK: if (timeout) state_d = ST_BERR;
                   else if (mem_ack_i) state_d = as_s_q ? ST_IDLE : ST_DTACK;
      ST_DTACK:    if (as_s_q) state_d = ST_IDLE;
      ST_BERR:     if (as_s_q) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output next values: capture on entry, release strobes on ack or timeout.
  always_comb begin
    mem_addr_d       = mem_addr_q;
    mem_data_write_d = mem_data_write_q;
    cpu_data_in_d    = cpu_data_in_q;
    mem_uds_d        = mem_uds_q;
    mem_lds_d        = mem_lds_q;
    mem_rw_d         = mem_rw_q;
    cpu_dtack_n_d    = cpu_dtack_n_q;
    cpu_berr_n_d     = cpu_berr_n_q;
    recover_d        = 1'b0;
    case (state_q)
      ST_IDLE: if (!timeout && sel) begin
        mem_addr_d       = {1'b0, cpu_addr_i[17:1]};
        mem_rw_d         = cpu_rw_i;
        mem_data_write_d = cpu_data_out_i;
        mem_uds_d        = ~uds_s_q;
        mem_lds_d        = ~lds_s_q;
      end
      ST_WAIT_ACK: if (!timeout && mem_ack_i) begin
        mem_uds_d = 1'b0;
        mem_lds_d = 1'b0;
        recover_d = 1'b1;
        if (!as_s_q) begin
          cpu_dtack_n_d = 1'b0;
          if (mem_rw_q) cpu_data_in_d = rd_lanes;
        end
      end
      ST_DTACK: if (as_s_q) cpu_dtack_n_d = 1'b1;
      ST_BERR:  if (as_s_q) cpu_berr_n_d = 1'b1;
      default: ;
    endcase
    if (timeout) begin
      cpu_berr_n_d = 1'b0;
      mem_uds_d    = 1'b0;
      mem_lds_d    = 1'b0;
      recover_d    = 1'b1;
    end
  end

  assign cpu_data_in_o    = cpu_data_in_q;
  assign cpu_dtack_n_o    = cpu_dtack_n_q;
  assign cpu_berr_n_o     = cpu_berr_n_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_data_write_o = mem_data_write_q;
  assign mem_uds_o        = mem_uds_q;
  assign mem_lds_o        = mem_lds_q;
  assign mem_rw_o         = mem_rw_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_m68k_mem_bridge.sv
// Bench for m68k_mem_bridge: a 68000-style CPU driver, a word memory that
// acks after a programmable delay, and a reference memory image that
// predicts read data and final memory contents.
`timescale 1ns/1ps
module tb_m68k_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:1] cpu_addr;
  logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
  logic [15:0] cpu_data_out, cpu_data_in;
  logic        cpu_dtack_n, cpu_berr_n;
  logic [17:0] mem_addr;
  logic [15:0] mem_data_write, mem_data_read;
  logic        mem_uds, mem_lds, mem_rw, mem_ack;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  m68k_mem_bridge dut (
    .clk_i(clk), .reset_i(rst), .cpu_addr_i(cpu_addr), .cpu_as_n_i(cpu_as_n),
    .cpu_uds_n_i(cpu_uds_n), .cpu_lds_n_i(cpu_lds_n), .cpu_rw_i(cpu_rw),
    .cpu_data_out_i(cpu_data_out), .cpu_data_in_o(cpu_data_in),
    .cpu_dtack_n_o(cpu_dtack_n), .cpu_berr_n_o(cpu_berr_n), .mem_addr_o(mem_addr),
    .mem_data_write_o(mem_data_write), .mem_data_read_i(mem_data_read),
    .mem_uds_o(mem_uds), .mem_lds_o(mem_lds), .mem_rw_o(mem_rw),
    .mem_ack_i(mem_ack), .dbg_state_o(dbg_state)
  );

  // memory environment
  logic [15:0] mem_arr [0:1023];
  logic [15:0] ref_mem [0:1023];
  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  int          dly_cnt;
  bit          busy;
  logic [17:0] last_ack_addr;
  logic [15:0] last_ack_wd;
  logic        last_ack_rw;
  logic [15:0] exp_q[$];

  assign mem_data_read = mem_arr[mem_addr[9:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ack <= 1'b0; busy <= 1'b0; dly_cnt <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_uds || mem_lds) begin
        if (!busy && ack_en) begin
          if (dly_cnt >= ack_delay) begin
            mem_ack <= 1'b1; busy <= 1'b1; dly_cnt <= 0;
            last_ack_addr <= mem_addr; last_ack_wd <= mem_data_write; last_ack_rw <= mem_rw;
            if (!mem_rw && mem_uds) mem_arr[mem_addr[9:0]][15:8] <= mem_data_write[15:8];
            if (!mem_rw && mem_lds) mem_arr[mem_addr[9:0]][7:0]  <= mem_data_write[7:0];
          end else dly_cnt <= dly_cnt + 1;
        end
      end else begin
        busy <= 1'b0; dly_cnt <= 0;
      end
    end
  end

  // strobe / handshake monitors, sampled on the falling edge
  bit uds_seen, strobe_seen, dtack_seen, prev_hi;
  int low_run, min_gap, rises;
  always @(negedge clk) begin
    if (mem_uds === 1'b1) uds_seen = 1'b1;
    if (cpu_dtack_n === 1'b0) dtack_seen = 1'b1;
    if (mem_uds === 1'b1 || mem_lds === 1'b1) begin
      strobe_seen = 1'b1;
      if (!prev_hi) begin
        if (rises > 0 && low_run < min_gap) min_gap = low_run;
        rises++;
      end
      prev_hi = 1'b1; low_run = 0;
    end else begin
      prev_hi = 1'b0; low_run++;
    end
  end

  // driver tasks
  task automatic cpu_idle();
    cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
  endtask

  task automatic cpu_start(input logic [23:0] baddr, input bit rd, input bit un,
                           input bit ln, input logic [15:0] wd);
    @(posedge clk); #2;
    cpu_addr = baddr[23:1]; cpu_rw = rd; cpu_data_out = wd;
    cpu_as_n = 1'b0; cpu_uds_n = un; cpu_lds_n = ln;
  endtask

  // lat: edges after edge 0 until DTACK low; rel: edges until DTACK high again
  task automatic cpu_cycle(input logic [23:0] baddr, input bit rd, input bit un,
                           input bit ln, input logic [15:0] wd, input bit quick,
                           output logic [15:0] rdata, output int lat, output int rel);
    cpu_start(baddr, rd, un, ln, wd);
    lat = -1; rel = -1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (cpu_dtack_n === 1'b0) begin lat = n; break; end
    end
    rdata = cpu_data_in;
    #1; cpu_idle();
    if (quick) @(posedge clk);
    else if (lat >= 0) begin
      @(posedge clk);
      for (int n = 1; n <= 10; n++) begin
        @(posedge clk); #1;
        if (cpu_dtack_n === 1'b1) begin rel = n; break; end
      end
    end
  endtask

  function automatic logic [15:0] ref_read(input int idx, input bit un, input bit ln);
    logic [15:0] w;
    w = ref_mem[idx];
    return {un ? 8'h00 : w[15:8], ln ? 8'h00 : w[7:0]};
  endfunction

  function automatic void ref_write(input int idx, input bit un, input bit ln, input logic [15:0] wd);
    if (!un) ref_mem[idx][15:8] = wd[15:8];
    if (!ln) ref_mem[idx][7:0]  = wd[7:0];
  endfunction

  // tests
  task automatic test_reset();
    rst = 1'b1; cpu_idle(); cpu_addr = '0; cpu_rw = 1'b1; cpu_data_out = '0;
    repeat (3) @(posedge clk); #1;
    checks++; if (cpu_dtack_n !== 1'b1) begin failures++; $display("FAIL reset_dtack got=%b exp=1", cpu_dtack_n); end
    checks++; if (cpu_berr_n !== 1'b1) begin failures++; $display("FAIL reset_berr got=%b exp=1", cpu_berr_n); end
    checks++; if (mem_uds !== 1'b0 || mem_lds !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", mem_uds, mem_lds); end
    checks++; if (mem_rw !== 1'b1) begin failures++; $display("FAIL reset_mem_rw got=%b exp=1", mem_rw); end
    checks++; if (mem_addr !== 18'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_data_write !== 16'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_data_write); end
    checks++; if (cpu_data_in !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", cpu_data_in); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_word_write();
    logic [15:0] rd; int lat, rel;
    ack_delay = 0;
    cpu_cycle(24'h000100, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0, rd, lat, rel);
    ref_write(10'h080, 1'b0, 1'b0, 16'hBEEF);
    checks++; if (last_ack_addr !== 18'h00080) begin failures++; $display("FAIL ww_addr got=%h exp=00080", last_ack_addr); end
    checks++; if (last_ack_wd !== 16'hBEEF) begin failures++; $display("FAIL ww_wdata got=%h exp=beef", last_ack_wd); end
    checks++; if (last_ack_rw !== 1'b0) begin failures++; $display("FAIL ww_rw got=%b exp=0", last_ack_rw); end
    checks++; if (lat != 4) begin failures++; $display("FAIL ww_latency got=%0d exp=4", lat); end
    checks++; if (rel != 2) begin failures++; $display("FAIL ww_release got=%0d exp=2", rel); end
    checks++; if (mem_arr[10'h080] !== ref_mem[10'h080]) begin failures++; $display("FAIL ww_mem got=%h exp=%h", mem_arr[10'h080], ref_mem[10'h080]); end
  endtask

  task automatic test_byte_read();
    logic [15:0] rd; int lat, rel;
    ack_delay = 1;
    cpu_cycle(24'h000040, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, rd, lat, rel);
    ref_write(10'h020, 1'b0, 1'b0, 16'h1234);
    uds_seen = 1'b0; ack_delay = 0;
    exp_q.push_back(ref_read(10'h020, 1'b1, 1'b0));
    cpu_cycle(24'h000040, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, rd, lat, rel);
    checks++; if (rd !== exp_q[0]) begin failures++; $display("FAIL br_data got=%h exp=%h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (rd !== 16'h0034) begin failures++; $display("FAIL br_data_const got=%h exp=0034", rd); end
    checks++; if (uds_seen) begin failures++; $display("FAIL br_uds_quiet got=1 exp=0"); end
    checks++; if (lat != 4) begin failures++; $display("FAIL br_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; int lat1, lat2, rel;
    ack_delay = 0; min_gap = 1000; rises = 0;
    cpu_cycle(24'h000080, 1'b0, 1'b0, 1'b0, 16'h1111, 1'b1, rd, lat1, rel);
    cpu_cycle(24'h000082, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b0, rd, lat2, rel);
    ref_write(10'h040, 1'b0, 1'b0, 16'h1111);
    ref_write(10'h041, 1'b0, 1'b0, 16'h2222);
    checks++; if (lat1 != 4 || lat2 != 4) begin failures++; $display("FAIL b2b_latency got=%0d,%0d exp=4,4", lat1, lat2); end
    checks++; if (rises != 2) begin failures++; $display("FAIL b2b_rises got=%0d exp=2", rises); end
    checks++; if (min_gap < 2) begin failures++; $display("FAIL b2b_gap got=%0d exp>=2", min_gap); end
    checks++; if (mem_arr[10'h040] !== ref_mem[10'h040]) begin failures++; $display("FAIL b2b_mem0 got=%h exp=%h", mem_arr[10'h040], ref_mem[10'h040]); end
    checks++; if (mem_arr[10'h041] !== ref_mem[10'h041]) begin failures++; $display("FAIL b2b_mem1 got=%h exp=%h", mem_arr[10'h041], ref_mem[10'h041]); end
  endtask

  task automatic test_unselected();
    int berr_edge;
    strobe_seen = 1'b0; dtack_seen = 1'b0; berr_edge = -1;
    cpu_start(24'h400000, 1'b1, 1'b0, 1'b0, 16'h0);
    @(posedge clk);
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (cpu_berr_n === 1'b0 && berr_edge < 0) berr_edge = n;
    end
    checks++; if (strobe_seen) begin failures++; $display("FAIL unsel_strobes got=1 exp=0"); end
    checks++; if (dtack_seen) begin failures++; $display("FAIL unsel_dtack got=0 exp=1"); end
`ifdef BUS_TIMEOUT_EN
    checks++; if (berr_edge < 255 || berr_edge > 258) begin failures++; $display("FAIL unsel_berr_edge got=%0d exp=255..258", berr_edge); end
    cpu_idle();
    repeat (4) @(posedge clk); #1;
    checks++; if (cpu_berr_n !== 1'b1) begin failures++; $display("FAIL unsel_berr_release got=%b exp=1", cpu_berr_n); end
`else
    checks++; if (berr_edge != -1) begin failures++; $display("FAIL unsel_berr got=edge%0d exp=never", berr_edge); end
    cpu_idle();
`endif
    repeat (3) @(posedge clk);
  endtask

  task automatic test_abort();
    bit up, acked;
    ack_delay = 3; up = 0; acked = 0;
    cpu_start(24'h000060, 1'b0, 1'b0, 1'b0, 16'h5A5A);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (mem_uds === 1'b1) begin up = 1; break; end
    end
    cpu_idle(); dtack_seen = 1'b0;
    ref_write(10'h030, 1'b0, 1'b0, 16'h5A5A);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_ack === 1'b1) begin acked = 1; break; end
    end
    @(posedge clk); #1;
    checks++; if (!up || !acked) begin failures++; $display("FAIL abort_handshake got=up%0d,ack%0d exp=up1,ack1", up, acked); end
    checks++; if (mem_uds !== 1'b0 || mem_lds !== 1'b0) begin failures++; $display("FAIL abort_strobe_drop got=%b%b exp=00", mem_uds, mem_lds); end
    repeat (10) @(posedge clk);
    checks++; if (dtack_seen) begin failures++; $display("FAIL abort_no_dtack got=1 exp=0"); end
    checks++; if (mem_arr[10'h030] !== ref_mem[10'h030]) begin failures++; $display("FAIL abort_mem got=%h exp=%h", mem_arr[10'h030], ref_mem[10'h030]); end
  endtask

  task automatic test_random();
    logic [15:0] rd, wd; int lat, rel, idx, s, bad; bit r, un, ln, quick;
    for (int i = 0; i < 16; i++) begin
      wd = 16'($urandom); ack_delay = $urandom_range(0, 3);
      cpu_cycle({13'd0, 10'(10'h100 + i), 1'b0}, 1'b0, 1'b0, 1'b0, wd, 1'b0, rd, lat, rel);
      ref_write(10'h100 + i, 1'b0, 1'b0, wd);
      checks++; if (lat != 4 + ack_delay) begin failures++; $display("FAIL rnd_init_latency got=%0d exp=%0d", lat, 4 + ack_delay); end
    end
    for (int i = 0; i < 40; i++) begin
      idx = 10'h100 + $urandom_range(0, 15);
      r = 1'($urandom_range(0, 1)); s = $urandom_range(1, 3);
      un = (s & 2) == 0; ln = (s & 1) == 0;
      wd = 16'($urandom); quick = 1'($urandom_range(0, 1));
      ack_delay = $urandom_range(0, 3);
      if (r) exp_q.push_back(ref_read(idx, un, ln));
      cpu_cycle({13'd0, 10'(idx), 1'b0}, r, un, ln, wd, quick, rd, lat, rel);
      if (!r) ref_write(idx, un, ln, wd);
      checks++; if (lat != 4 + ack_delay) begin failures++; $display("FAIL rnd_latency op%0d got=%0d exp=%0d", i, lat, 4 + ack_delay); end
      if (r) begin
        checks++; if (rd !== exp_q[0]) begin failures++; $display("FAIL rnd_read op%0d got=%h exp=%h", i, rd, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    repeat (4) @(posedge clk);
    bad = 0;
    for (int i = 10'h100; i < 10'h110; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rnd_mem_image got=%0d_bad_words exp=0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; int lat, rel; bit up;
    ack_en = 1'b0; up = 0;
    cpu_start(24'h000100, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (mem_uds === 1'b1) begin up = 1; break; end
    end
    repeat (2) @(posedge clk);
    #3; rst = 1'b1; #1;
    checks++; if (!up) begin failures++; $display("FAIL rmid_started got=0 exp=1"); end
    checks++; if (mem_uds !== 1'b0 || mem_lds !== 1'b0) begin failures++; $display("FAIL rmid_strobes got=%b%b exp=00", mem_uds, mem_lds); end
    checks++; if (cpu_dtack_n !== 1'b1) begin failures++; $display("FAIL rmid_dtack got=%b exp=1", cpu_dtack_n); end
    checks++; if (cpu_berr_n !== 1'b1) begin failures++; $display("FAIL rmid_berr got=%b exp=1", cpu_berr_n); end
    cpu_idle();
    @(negedge clk); rst = 1'b0; ack_en = 1'b1; ack_delay = 0;
    repeat (3) @(posedge clk);
    exp_q.push_back(ref_read(10'h080, 1'b0, 1'b0));
    cpu_cycle(24'h000100, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, rd, lat, rel);
    checks++; if (rd !== exp_q[0]) begin failures++; $display("FAIL rmid_next_read got=%h exp=%h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (lat != 4) begin failures++; $display("FAIL rmid_next_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    prev_hi = 0; low_run = 0; min_gap = 1000; rises = 0;
    uds_seen = 0; strobe_seen = 0; dtack_seen = 0;
    test_reset();
    test_word_write();
    test_byte_read();
    test_back_to_back();
    test_unselected();
    test_abort();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
